// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Optional completion counters (stat_cnt0/stat_cnt1) are built when ALU_ARB_STAT_EN is defined.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_C,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_C,
  output logic [1:0]       state
`ifdef ALU_ARB_STAT_EN
  ,
  output logic [31:0]      stat_cnt0,
  output logic [31:0]      stat_cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_code;
  logic [3:0]       cnt;
  logic             ptr;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // Requesters only see ready in IDLE, and only the granted one; the response
  // channel holds valid/data stable until the consumer's ready is seen.
  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || ptr);

  assign alu_A  = op_a;
  assign alu_B  = op_b;
  assign alu_op = op_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      rsp_C     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      cnt       <= 4'd0;
      ptr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req0_ready) begin
            op_a    <= req0_A;
            op_b    <= req0_B;
            op_code <= req0_op;
            rsp_id  <= 1'b0;
            ptr     <= 1'b1;
            cnt     <= CNT_INIT;
            state   <= EXEC;
          end else if (req1_valid && req1_ready) begin
            op_a    <= req1_A;
            op_b    <= req1_B;
            op_code <= req1_op;
            rsp_id  <= 1'b1;
            ptr     <= 1'b0;
            cnt     <= CNT_INIT;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_C     <= alu_C;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt0 <= 32'd0;
      stat_cnt1 <= 32'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id) stat_cnt1 <= stat_cnt1 + 32'd1;
      else        stat_cnt0 <= stat_cnt0 + 32'd1;
    end
  end
`else
  // Completion counters are not present in this build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES 1 and 4) share stimulus, each with
// a transaction-level model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0;
  logic req1_valid = 1'b0;
  logic rsp_ready = 1'b1;
  logic [W-1:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [2:0] req0_op = '0, req1_op = '0;

  logic req0_ready[2], req1_ready[2], rsp_valid[2], rsp_id[2];
  logic [W-1:0] alu_A[2], alu_B[2], alu_C[2], rsp_C[2];
  logic [2:0] alu_op[2];
  logic [1:0] state[2];
`ifdef ALU_ARB_STAT_EN
  logic [31:0] stat_cnt0[2], stat_cnt1[2];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ALU stub: C = A ^ B
  assign alu_C[0] = alu_A[0] ^ alu_B[0];
  assign alu_C[1] = alu_A[1] ^ alu_B[1];

  alu_arbiter #(.WIDTH(W), .OPW(3), .EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready[0]), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready[0]), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .alu_A(alu_A[0]), .alu_B(alu_B[0]), .alu_op(alu_op[0]), .alu_C(alu_C[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[0]), .rsp_C(rsp_C[0]),
    .state(state[0])
`ifdef ALU_ARB_STAT_EN
    , .stat_cnt0(stat_cnt0[0]), .stat_cnt1(stat_cnt1[0])
`endif
  );

  alu_arbiter #(.WIDTH(W), .OPW(3), .EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready[1]), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready[1]), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .alu_A(alu_A[1]), .alu_B(alu_B[1]), .alu_op(alu_op[1]), .alu_C(alu_C[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[1]), .rsp_C(rsp_C[1]),
    .state(state[1])
`ifdef ALU_ARB_STAT_EN
    , .stat_cnt0(stat_cnt0[1]), .stat_cnt1(stat_cnt1[1])
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model per instance: busy for EC cycles after accept, then a
  // pending response until it is taken; grant goes to the requester not served last.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int EC = (g == 0) ? 1 : 4;
    int exec_left = 0;
    bit pend = 1'b0;
    bit ptr = 1'b0;
    bit id = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic [2:0] op = '0;
    logic [31:0] st0 = '0, st1 = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        exec_left = 0; pend = 1'b0; ptr = 1'b0; id = 1'b0;
        a = '0; b = '0; c = '0; op = '0; st0 = '0; st1 = '0;
      end else if (pend) begin
        if (rsp_ready) begin
          pend = 1'b0;
          if (id) st1 = st1 + 32'd1;
          else    st0 = st0 + 32'd1;
        end
      end else if (exec_left > 0) begin
        exec_left--;
        if (exec_left == 0) begin
          pend = 1'b1;
          c = a ^ b;
        end
      end else if (req0_valid || req1_valid) begin
        id = (req0_valid && req1_valid) ? ptr : req1_valid;
        a  = id ? req1_A  : req0_A;
        b  = id ? req1_B  : req0_B;
        op = id ? req1_op : req0_op;
        ptr = !id;
        exec_left = EC;
      end
    end

    always @(negedge clk) begin
      bit idle, w0, w1;
      idle = !pend && (exec_left == 0);
      w0 = idle && req0_valid && (!req1_valid || !ptr);
      w1 = idle && req1_valid && (!req0_valid || ptr);
      check($sformatf("u%0d.req0_ready", g), 64'(req0_ready[g]), 64'(w0));
      check($sformatf("u%0d.req1_ready", g), 64'(req1_ready[g]), 64'(w1));
      check($sformatf("u%0d.rsp_valid", g), 64'(rsp_valid[g]), 64'(pend));
      check($sformatf("u%0d.alu_A", g), 64'(alu_A[g]), 64'(a));
      check($sformatf("u%0d.alu_B", g), 64'(alu_B[g]), 64'(b));
      check($sformatf("u%0d.alu_op", g), 64'(alu_op[g]), 64'(op));
      if (pend) begin
        check($sformatf("u%0d.rsp_C", g), 64'(rsp_C[g]), 64'(c));
        check($sformatf("u%0d.rsp_id", g), 64'(rsp_id[g]), 64'(id));
      end
`ifdef ALU_ARB_STAT_EN
      check($sformatf("u%0d.stat_cnt0", g), 64'(stat_cnt0[g]), 64'(st0));
      check($sformatf("u%0d.stat_cnt1", g), 64'(stat_cnt1[g]), 64'(st1));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Returns at the negedge where rsp_valid[idx] is first seen, or flags a timeout.
  task automatic wait_rsp(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[idx]) seen = 1'b1;
    end
    if (!seen) check("wait_rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ids[4];
    logic [W-1:0] cs[4];
    int          ts[4];
    int          n;
    bit          who[5];

    // Reset state
    ticks(2);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("reset_alu_A", 64'(alu_A[0]), 64'd0);
    check("reset_alu_op", 64'(alu_op[0]), 64'd0);
    check("reset_rsp_C", 64'(rsp_C[0]), 64'd0);

    // Single req0 op, EXEC_CYCLES=1
    tick();
    req0_A = 32'hffff0000; req0_B = 32'h00000003; req0_op = 3'b101; req0_valid = 1'b1;
    @(negedge clk);
    check("t1_req0_ready", 64'(req0_ready[0]), 64'd1);
    check("t1_req1_ready", 64'(req1_ready[0]), 64'd0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_alu_A", 64'(alu_A[0]), 64'h00000000ffff0000);
    check("t1_alu_op", 64'(alu_op[0]), 64'd5);
    check("t1_rsp_valid_exec", 64'(rsp_valid[0]), 64'd0);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check("t1_rsp_C", 64'(rsp_C[0]), 64'h00000000ffff0003);
    check("t1_rsp_id", 64'(rsp_id[0]), 64'd0);
    tick();
    ticks(6);

    // Both valid from reset: strict alternation, one response every 3 cycles
    req0_A = 32'd1; req0_B = 32'd2; req0_op = 3'd0;
    req1_A = 32'd4; req1_B = 32'd8; req1_op = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1; reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (rsp_valid[0] && n < 4) begin
        ids[n] = rsp_id[0]; cs[n] = rsp_C[0]; ts[n] = cyc; n++;
      end
    end
    check("t2_count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_id%0d", k), 64'(ids[k]), 64'(k % 2));
      check($sformatf("t2_C%0d", k), 64'(cs[k]), (k % 2 == 0) ? 64'd3 : 64'd12);
      if (k > 0) check($sformatf("t2_gap%0d", k), 64'(ts[k] - ts[k-1]), 64'd3);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ticks(8);

    // Response back-pressure
    rsp_ready = 1'b0;
    req1_A = 32'd5; req1_B = 32'd3; req1_op = 3'd2; req1_valid = 1'b1;
    wait_rsp(0, 10);
    tick();
    req0_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(rsp_valid[0]), 64'd1);
      check("t3_hold_C", 64'(rsp_C[0]), 64'd6);
      check("t3_hold_id", 64'(rsp_id[0]), 64'd1);
      check("t3_ready0_low", 64'(req0_ready[0]), 64'd0);
      check("t3_ready1_low", 64'(req1_ready[0]), 64'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_release_valid", 64'(rsp_valid[0]), 64'd1);
    check("t3_release_ready", 64'(req0_ready[0] | req1_ready[0]), 64'd0);
    @(negedge clk);
    check("t3_idle_valid", 64'(rsp_valid[0]), 64'd0);
    check("t3_idle_ready", 64'(req0_ready[0] | req1_ready[0]), 64'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ticks(10);

    // Reset during EXEC discards the op and restores the pointer
    req0_A = 32'h12345678; req0_B = 32'h1; req0_op = 3'd4; req0_valid = 1'b1;
    @(negedge clk);
    check("t5_req0_ready", 64'(req0_ready[0]), 64'd1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid_rst", 64'(rsp_valid[0]), 64'd0);
    check("t5_alu_A_rst", 64'(alu_A[0]), 64'd0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("t5_ptr_req0", 64'(req0_ready[0]), 64'd1);
    check("t5_ptr_req1", 64'(req1_ready[0]), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ticks(10);

    // EXEC_CYCLES=4 instance
    req1_A = 32'h0000ffff; req1_B = 32'hffffffff; req1_op = 3'd3; req1_valid = 1'b1;
    @(negedge clk);
    check("t4_req1_ready", 64'(req1_ready[1]), 64'd1);
    tick();
    req1_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t4_alu_A", 64'(alu_A[1]), 64'h000000000000ffff);
      check("t4_alu_B", 64'(alu_B[1]), 64'h00000000ffffffff);
      check("t4_rsp_valid_exec", 64'(rsp_valid[1]), 64'd0);
    end
    @(negedge clk);
    check("t4_rsp_valid", 64'(rsp_valid[1]), 64'd1);
    check("t4_rsp_C", 64'(rsp_C[1]), 64'h00000000ffff0000);
    check("t4_rsp_id", 64'(rsp_id[1]), 64'd1);
    tick();
    ticks(4);

    // Completion count: 3 req0 ops and 2 req1 ops
    reset = 1'b1;
    tick();
    reset = 1'b0;
    who[0] = 1'b0; who[1] = 1'b1; who[2] = 1'b0; who[3] = 1'b1; who[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (who[k]) req1_valid = 1'b1;
      else        req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      ticks(7);
    end
`ifdef ALU_ARB_STAT_EN
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stat0_u%0d", i), 64'(stat_cnt0[i]), 64'd3);
      check($sformatf("stat1_u%0d", i), 64'(stat_cnt1[i]), 64'd2);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("stat0_clear", 64'(stat_cnt0[0]), 64'd0);
    check("stat1_clear", 64'(stat_cnt1[0]), 64'd0);
    tick();
    reset = 1'b0;
`endif
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu datapath (A, B, ALUOp -> C) between two requesters using round-robin arbitration.
- Each requester offers an operand/op triple over a valid/ready handshake.
- The block latches the winner's operands and holds them on the ALU inputs for a programmable number of cycles.
- It captures C and returns it, tagged with the requester id, over a valid/ready response channel.
- It sits between the two issuing front-ends and the single alu instance.

Parameters:
WIDTH, 32, operand/result width (A, B, C)
OPW, 3, ALUOp width
EXEC_CYCLES, 1, cycles operands are held on the ALU before C is sampled (1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle (valid&&ready = handshake)
req0_A  in  WIDTH  requester 0 operand A
req0_B  in  WIDTH  requester 0 operand B
req0_op  in  OPW  requester 0 ALUOp
req1_valid/req1_ready/req1_A/req1_B/req1_op  same as requester 0, for requester 1
alu_A  out  WIDTH  to alu A
alu_B  out  WIDTH  to alu B
alu_op  out  OPW  to alu ALUOp
alu_C  in  WIDTH  from alu C (combinational)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the result
rsp_C  out  WIDTH  result

Behaviour:
- States: IDLE, EXEC, RESP. Reset (async) forces IDLE and clears:
  - operand registers, op register and rsp_C to 0
  - rsp_valid and rsp_id to 0
  - exec counter to 0
  - priority pointer to 0 (requester 0 favoured)
- reqN_ready is combinational: 1 only in IDLE and when N is the grant. Never 1 in EXEC/RESP. At most one ready per cycle.
- Grant in IDLE:
  - both valid -> requester named by the priority pointer
  - only one valid -> that one
  - none -> no grant, stay IDLE
- IDLE, on handshake:
  - latch reqN_A/B/op into the operand registers and N into the id register
  - exec counter = EXEC_CYCLES-1
  - pointer = 1-N
  - go to EXEC
- EXEC:
  - alu_A/alu_B/alu_op are driven from the operand registers at all times, not just in EXEC, and are stable for the whole op
  - if counter==0: rsp_C <= alu_C, rsp_valid <= 1, go to RESP
  - else decrement the counter
- RESP:
  - rsp_valid, rsp_C and rsp_id are held constant until rsp_ready==1
  - on that cycle, rsp_valid <= 0 and go to IDLE
  - the next request cannot be accepted in that same cycle; acceptance starts the following cycle
- Latency: accept at edge T; rsp_valid rises at edge T+EXEC_CYCLES; minimum issue interval is EXEC_CYCLES+2 cycles with rsp_ready tied 1.
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1...
- Requester changing operands while its ready==0 has no effect; operands are sampled only on handshake.
- A requester dropping valid before handshake is legal; it is simply not granted.
- rsp_ready asserted while rsp_valid==0 is ignored.
- Reset mid-EXEC or mid-RESP: in-flight op is discarded, no response is emitted, and outputs return to reset values immediately (asynchronous).
- Arithmetic is performed only by the external alu; this block does no width conversion and passes WIDTH bits straight through.

Optional Feature:
ALU_ARB_STAT_EN
- Defined: adds outputs stat_cnt0 and stat_cnt1 (32 bits each).
  - Each counts completed responses (rsp_valid&&rsp_ready) for its id.
  - Reset to 0; wrap from 32'hffffffff to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench alu stub drives alu_C = alu_A ^ alu_B; EXEC_CYCLES=1; rsp_ready=1.
  - req0 A=32'hffff0000, B=32'h00000003, op=3'b101 -> req0_ready pulses in IDLE
  - one cycle later alu_A=32'hffff0000, alu_op=3'b101
  - rsp_valid=1 with rsp_C=32'hffff0003, rsp_id=0 one cycle after accept
- Both valid held high from reset, req0 A=1 B=2 and req1 A=4 B=8 -> responses alternate id 0 (C=3), id 1 (C=12), id 0, id 1 at one every 3 cycles.
- rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_C and rsp_id stable throughout; both req readys stay 0; IDLE entered the cycle after rsp_ready=1.
- EXEC_CYCLES=4; req1 A=32'h0000ffff, B=32'hffffffff -> alu inputs held 4 cycles; rsp_C=32'hffff0000, rsp_id=1 at accept+4.
- Assert reset during EXEC of a req0 op -> rsp_valid stays 0 and no response appears; after release, the pointer is 0 (req0 wins when both are valid).
- With ALU_ARB_STAT_EN defined: 3 req0 ops and 2 req1 ops completed -> stat_cnt0=3, stat_cnt1=2; a reset clears both to 0.
